// File: rtl/cpunc_axi_pkg.sv
// Shared types, constants and helpers for the CPUNC AXI requester arbiter.
package cpunc_axi_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2,
    ILL  = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AWW,
    B,
    ERR,
    RSP
  } state_e;

  localparam logic [1:0] AXSIZE_WORD = 2'b10;
  localparam logic       RESP_OKAY   = 1'b0;

  // Byte-lane strobe for a right-justified access placed at addr_lo.
  function automatic logic [3:0] size_to_strb(input size_e size, input logic [1:0] addr_lo);
    logic [3:0] base;
    case (size)
      BYTE:    base = 4'b0001;
      HALF:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << addr_lo;
  endfunction

  // Illegal size code, or a half/word access that is not naturally aligned.
  function automatic logic access_illegal(input size_e size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = addr_lo[0];
      WORD:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Move the addressed lanes down to bit 0 and zero everything above the access size.
  function automatic logic [31:0] align_rdata(input logic [31:0] data, input logic [1:0] addr_lo,
                                              input size_e size);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = data >> {addr_lo, 3'b000};
    case (size)
      BYTE:    result = {24'h0, shifted[7:0]};
      HALF:    result = {16'h0, shifted[15:0]};
      default: result = shifted;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/cpunc_rr_arbiter.sv
// Combinational round-robin arbiter: searches the request vector starting one past ptr.
module cpunc_rr_arbiter
  import cpunc_axi_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  logic          found;
  logic [IW-1:0] idx;

  // First set request found walking ptr+1, ptr+2, ... with wrap-around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IW'((32'(ptr) + i + 32'd1) % 32'(NUM_REQ));
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/cpunc_axi_arbiter.sv
// Shares one CPUNC AXI master among NUM_REQ requesters, one single-beat transaction at a time.
module cpunc_axi_arbiter
  import cpunc_axi_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_MASK_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                              CPUNC_ACLK,
  input  logic                              CPUNC_ARESETn,
  // requester side
  input  logic [NUM_REQ-1:0]                REQ_VALID,
  output logic [NUM_REQ-1:0]                REQ_READY,
  input  logic [NUM_REQ-1:0]                REQ_WE,
  input  logic [2*NUM_REQ-1:0]              REQ_SIZE,
  input  logic [AXI_ADDR_WIDTH*NUM_REQ-1:0] REQ_ADDR,
  input  logic [AXI_DATA_WIDTH*NUM_REQ-1:0] REQ_WDATA,
  output logic [NUM_REQ-1:0]                RSP_VALID,
  output logic [AXI_DATA_WIDTH-1:0]         RSP_RDATA,
  output logic                              RSP_ERR,
  // write address channel
  output logic [7:0]                        CPUNC_AWID,
  output logic [AXI_ADDR_WIDTH-1:0]         CPUNC_AWADDR,
  output logic [7:0]                        CPUNC_AWLEN,
  output logic [1:0]                        CPUNC_AWSIZE,
  output logic [1:0]                        CPUNC_AWBURST,
  output logic                              CPUNC_AWLOCK,
  output logic [3:0]                        CPUNC_AWCACHE,
  output logic [2:0]                        CPUNC_AWPROT,
  output logic [3:0]                        CPUNC_AWQOS,
  output logic                              CPUNC_AWVALID,
  input  logic                              CPUNC_AWREADY,
  // write data channel
  output logic [7:0]                        CPUNC_WID,
  output logic [AXI_DATA_WIDTH-1:0]         CPUNC_WDATA,
  output logic [AXI_MASK_WIDTH-1:0]         CPUNC_WSTRB,
  output logic                              CPUNC_WLAST,
  output logic                              CPUNC_WVALID,
  input  logic                              CPUNC_WREADY,
  // write response channel
  input  logic [7:0]                        CPUNC_BID,
  input  logic                              CPUNC_BRESP,
  input  logic                              CPUNC_BVALID,
  output logic                              CPUNC_BREADY,
  // read address channel
  output logic [7:0]                        CPUNC_ARID,
  output logic [AXI_ADDR_WIDTH-1:0]         CPUNC_ARADDR,
  output logic [7:0]                        CPUNC_ARLEN,
  output logic [1:0]                        CPUNC_ARSIZE,
  output logic [1:0]                        CPUNC_ARBURST,
  output logic                              CPUNC_ARLOCK,
  output logic [3:0]                        CPUNC_ARCACHE,
  output logic [2:0]                        CPUNC_ARPROT,
  output logic [3:0]                        CPUNC_ARQOS,
  output logic                              CPUNC_ARVALID,
  input  logic                              CPUNC_ARREADY,
  // read data channel
  input  logic [7:0]                        CPUNC_RID,
  input  logic [AXI_DATA_WIDTH-1:0]         CPUNC_RDATA,
  input  logic                              CPUNC_RRESP,
  input  logic                              CPUNC_RLAST,
  input  logic                              CPUNC_RVALID,
  output logic                              CPUNC_RREADY
);

  localparam int IW = $clog2(NUM_REQ);

  // Per-requester views of the packed request buses.
  logic [AXI_ADDR_WIDTH-1:0] req_addr  [NUM_REQ];
  logic [AXI_DATA_WIDTH-1:0] req_wdata [NUM_REQ];
  size_e                     req_size  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_addr[gi]  = REQ_ADDR[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    assign req_wdata[gi] = REQ_WDATA[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign req_size[gi]  = size_e'(REQ_SIZE[2*gi +: 2]);
  end

  // State and registered outputs (q) with their next values (d).
  state_e                    state_q,     state_d;
  logic [IW-1:0]             ptr_q,       ptr_d;
  logic [IW-1:0]             lat_g_q,     lat_g_d;
  logic [1:0]                lat_lo_q,    lat_lo_d;
  size_e                     lat_size_q,  lat_size_d;
  logic [7:0]                id_q,        id_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q,    araddr_d;
  logic                      arvalid_q,   arvalid_d;
  logic                      rready_q,    rready_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q,    awaddr_d;
  logic                      awvalid_q,   awvalid_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic [AXI_MASK_WIDTH-1:0] wstrb_q,     wstrb_d;
  logic                      wlast_q,     wlast_d;
  logic                      wvalid_q,    wvalid_d;
  logic                      bready_q,    bready_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q,   rsp_err_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0]        grant;
  logic [IW-1:0]             grant_idx;
  logic                      arb_en;

  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [AXI_DATA_WIDTH-1:0] sel_wdata;
  size_e                     sel_size;
  logic                      sel_we;
  logic [NUM_REQ-1:0]        owner_onehot;

  assign arb_en = (state_q == IDLE);

  cpunc_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req      (REQ_VALID),
    .ptr      (ptr_q),
    .en       (arb_en),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // REQ_READY is the only combinational output; it must stay low while reset is asserted.
  assign REQ_READY = CPUNC_ARESETn ? grant : '0;

  assign sel_addr     = req_addr[grant_idx];
  assign sel_wdata    = req_wdata[grant_idx];
  assign sel_size     = req_size[grant_idx];
  assign sel_we       = REQ_WE[grant_idx];
  assign owner_onehot = NUM_REQ'(1) << lat_g_q;

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lat_g_d     = lat_g_q;
    lat_lo_d    = lat_lo_q;
    lat_size_d  = lat_size_q;
    id_d        = id_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wlast_d     = wlast_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (|grant) begin
          ptr_d      = grant_idx;
          lat_g_d    = grant_idx;
          lat_lo_d   = sel_addr[1:0];
          lat_size_d = sel_size;
          id_d       = 8'(grant_idx);
          if (access_illegal(sel_size, sel_addr[1:0])) begin
            state_d = ERR;
          end else if (sel_we) begin
            state_d   = AWW;
            awaddr_d  = sel_addr;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wlast_d   = 1'b1;
            wstrb_d   = AXI_MASK_WIDTH'(size_to_strb(sel_size, sel_addr[1:0]));
            wdata_d   = sel_wdata << {sel_addr[1:0], 3'b000};
          end else begin
            state_d   = AR;
            araddr_d  = sel_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      AR: begin
        if (CPUNC_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (CPUNC_RVALID) begin
          rready_d    = 1'b0;
          state_d     = RSP;
          rsp_valid_d = owner_onehot;
          rsp_err_d   = (CPUNC_RRESP != RESP_OKAY) || (CPUNC_RID != id_q) || !CPUNC_RLAST;
          rsp_rdata_d = align_rdata(CPUNC_RDATA, lat_lo_q, lat_size_q);
        end
      end
      AWW: begin
        // Address and data channels retire independently; move on once both are done.
        if (awvalid_q && CPUNC_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && CPUNC_WREADY) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
        end
        if (!awvalid_d && !wvalid_d) begin
          state_d  = B;
          bready_d = 1'b1;
        end
      end
      B: begin
        if (CPUNC_BVALID) begin
          bready_d    = 1'b0;
          state_d     = RSP;
          rsp_valid_d = owner_onehot;
          rsp_err_d   = (CPUNC_BRESP != RESP_OKAY) || (CPUNC_BID != id_q);
        end
      end
      ERR: begin
        state_d     = RSP;
        rsp_valid_d = owner_onehot;
        rsp_err_d   = 1'b1;
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and round-robin pointer; pointer resets so requester 0 wins first.
  always_ff @(posedge CPUNC_ACLK or negedge CPUNC_ARESETn) begin
    if (!CPUNC_ARESETn) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Latched request context and all registered AXI / response outputs.
  always_ff @(posedge CPUNC_ACLK or negedge CPUNC_ARESETn) begin
    if (!CPUNC_ARESETn) begin
      lat_g_q     <= '0;
      lat_lo_q    <= '0;
      lat_size_q  <= BYTE;
      id_q        <= '0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wlast_q     <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      lat_g_q     <= lat_g_d;
      lat_lo_q    <= lat_lo_d;
      lat_size_q  <= lat_size_d;
      id_q        <= id_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wlast_q     <= wlast_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign RSP_VALID     = rsp_valid_q;
  assign RSP_ERR       = rsp_err_q;
  assign RSP_RDATA     = rsp_rdata_q;

  assign CPUNC_AWID    = id_q;
  assign CPUNC_ARID    = id_q;
  assign CPUNC_WID     = id_q;
  assign CPUNC_AWADDR  = awaddr_q;
  assign CPUNC_AWVALID = awvalid_q;
  assign CPUNC_WDATA   = wdata_q;
  assign CPUNC_WSTRB   = wstrb_q;
  assign CPUNC_WLAST   = wlast_q;
  assign CPUNC_WVALID  = wvalid_q;
  assign CPUNC_BREADY  = bready_q;
  assign CPUNC_ARADDR  = araddr_q;
  assign CPUNC_ARVALID = arvalid_q;
  assign CPUNC_RREADY  = rready_q;

  assign CPUNC_AWLEN   = '0;
  assign CPUNC_AWSIZE  = AXSIZE_WORD;
  assign CPUNC_AWBURST = '0;
  assign CPUNC_AWLOCK  = 1'b0;
  assign CPUNC_AWCACHE = '0;
  assign CPUNC_AWPROT  = '0;
  assign CPUNC_AWQOS   = '0;
  assign CPUNC_ARLEN   = '0;
  assign CPUNC_ARSIZE  = AXSIZE_WORD;
  assign CPUNC_ARBURST = '0;
  assign CPUNC_ARLOCK  = 1'b0;
  assign CPUNC_ARCACHE = '0;
  assign CPUNC_ARPROT  = '0;
  assign CPUNC_ARQOS   = '0;

endmodule

// File: tb/tb_cpunc_axi_arbiter.sv
// Directed self-checking bench for cpunc_axi_arbiter with two requesters.
module tb_cpunc_axi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [3:0]  req_size;
  logic [23:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  awid, wid, arid, awlen, arlen, bid, rid;
  logic [11:0] awaddr, araddr;
  logic [1:0]  awsize, arsize, awburst, arburst;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache, awqos, arqos, wstrb;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wlast, wvalid, wready, bresp, bvalid, bready;
  logic        arvalid, arready, rresp, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpunc_axi_arbiter #(
    .NUM_REQ(2),
    .AXI_ADDR_WIDTH(12),
    .AXI_DATA_WIDTH(32)
  ) dut (
    .CPUNC_ACLK(clk), .CPUNC_ARESETn(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we), .REQ_SIZE(req_size),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .CPUNC_AWID(awid), .CPUNC_AWADDR(awaddr), .CPUNC_AWLEN(awlen), .CPUNC_AWSIZE(awsize),
    .CPUNC_AWBURST(awburst), .CPUNC_AWLOCK(awlock), .CPUNC_AWCACHE(awcache),
    .CPUNC_AWPROT(awprot), .CPUNC_AWQOS(awqos), .CPUNC_AWVALID(awvalid), .CPUNC_AWREADY(awready),
    .CPUNC_WID(wid), .CPUNC_WDATA(wdata), .CPUNC_WSTRB(wstrb), .CPUNC_WLAST(wlast),
    .CPUNC_WVALID(wvalid), .CPUNC_WREADY(wready),
    .CPUNC_BID(bid), .CPUNC_BRESP(bresp), .CPUNC_BVALID(bvalid), .CPUNC_BREADY(bready),
    .CPUNC_ARID(arid), .CPUNC_ARADDR(araddr), .CPUNC_ARLEN(arlen), .CPUNC_ARSIZE(arsize),
    .CPUNC_ARBURST(arburst), .CPUNC_ARLOCK(arlock), .CPUNC_ARCACHE(arcache),
    .CPUNC_ARPROT(arprot), .CPUNC_ARQOS(arqos), .CPUNC_ARVALID(arvalid), .CPUNC_ARREADY(arready),
    .CPUNC_RID(rid), .CPUNC_RDATA(rdata), .CPUNC_RRESP(rresp), .CPUNC_RLAST(rlast),
    .CPUNC_RVALID(rvalid), .CPUNC_RREADY(rready)
  );

  task automatic set_req(input int r, input logic we, input logic [1:0] size,
                         input logic [11:0] addr, input logic [31:0] wd);
    req_we[r]             = we;
    req_size[2*r +: 2]    = size;
    req_addr[12*r +: 12]  = addr;
    req_wdata[32*r +: 32] = wd;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 2'b11; req_we = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    checks++; if ({arvalid, awvalid, wvalid, wlast, rready, bready, rsp_err, rsp_valid} !== 9'd0) begin
      failures++; $display("FAIL reset_ctl got=%b exp=0", {arvalid, awvalid, wvalid, wlast, rready, bready, rsp_err, rsp_valid}); end
    checks++; if ({araddr, awaddr, wdata, wstrb, awid, arid, wid, rsp_rdata} !== 116'd0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {araddr, awaddr, wdata, wstrb, awid, arid, wid, rsp_rdata}); end
    checks++; if ({awlen, arlen, awsize, arsize, awburst, arburst, awlock, arlock, awcache, arcache, awprot, arprot, awqos, arqos}
                  !== {8'h0, 8'h0, 2'b10, 2'b10, 2'b0, 2'b0, 1'b0, 1'b0, 4'h0, 4'h0, 3'h0, 3'h0, 4'h0, 4'h0}) begin
      failures++; $display("FAIL const_outputs awsize=%b arsize=%b awlen=%h", awsize, arsize, awlen); end
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read;
    set_req(0, 1'b0, 2'd2, 12'h010, 32'h0);
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rd_ready got=%b exp=01", req_ready); end
    @(negedge clk); req_valid = 2'b00; arready = 1'b1; #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 12'h010 || arid !== 8'd0) begin
      failures++; $display("FAIL rd_ar got=%b/%h/%h exp=1/010/00", arvalid, araddr, arid); end
    checks++; if (awvalid !== 1'b0 || req_ready !== 2'b00) begin
      failures++; $display("FAIL rd_no_aw got=%b/%b exp=0/00", awvalid, req_ready); end
    @(negedge clk); arready = 1'b0; #1;
    checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin
      failures++; $display("FAIL rd_r got=%b/%b exp=0/1", arvalid, rready); end
    rvalid = 1'b1; rdata = 32'hDEADBEEF; rid = 8'd0; rlast = 1'b1; rresp = 1'b0;
    @(negedge clk); rvalid = 1'b0; #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
      failures++; $display("FAIL rd_rsp got=%b/%h/%b exp=01/deadbeef/0", rsp_valid, rsp_rdata, rsp_err); end
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL rd_rready_drop got=%b exp=0", rready); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rd_rsp_pulse got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_byte_write;
    set_req(1, 1'b1, 2'd0, 12'h013, 32'h0000005A);
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL wr_ready got=%b exp=10", req_ready); end
    @(negedge clk); req_valid = 2'b00; awready = 1'b1; wready = 1'b1; #1;
    checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || wlast !== 1'b1 || awaddr !== 12'h013) begin
      failures++; $display("FAIL wr_aw got=%b%b%b/%h exp=111/013", awvalid, wvalid, wlast, awaddr); end
    checks++; if (wstrb !== 4'b1000 || wdata[31:24] !== 8'h5A || wid !== 8'd1 || awid !== 8'd1) begin
      failures++; $display("FAIL wr_payload got=%b/%h/%h/%h exp=1000/5a/01/01", wstrb, wdata[31:24], wid, awid); end
    @(negedge clk); awready = 1'b0; wready = 1'b0; #1;
    checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin
      failures++; $display("FAIL wr_b got=%b%b%b exp=001", awvalid, wvalid, bready); end
    bvalid = 1'b1; bid = 8'd1; bresp = 1'b0;
    @(negedge clk); bvalid = 1'b0; #1;
    checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL wr_rsp got=%b/%b/%h exp=10/0/0", rsp_valid, rsp_err, rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    int          exp_g[4] = '{0, 1, 0, 1};
    int          ng = 0, nr = 0, last_cyc = 0;
    logic [1:0]  exp_oh;
    set_req(0, 1'b0, 2'd2, 12'h020, 32'h0);
    set_req(1, 1'b0, 2'd2, 12'h024, 32'h0);
    arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rresp = 1'b0; rdata = 32'h11223344; rid = 8'd0;
    req_valid = 2'b11;
    for (int cyc = 0; cyc < 40 && nr < 4; cyc++) begin
      #1;
      if (req_ready != 2'b00 && ng < 4) begin
        exp_oh = 2'b01 << exp_g[ng];
        checks++; if (req_ready !== exp_oh) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", ng, req_ready, exp_oh); end
        if (ng > 0) begin
          checks++; if (cyc - last_cyc !== 4) begin failures++; $display("FAIL rr_spacing%0d got=%0d exp=4", ng, cyc - last_cyc); end
        end
        last_cyc = cyc; rid = 8'(exp_g[ng]); ng++;
      end
      if (rsp_valid != 2'b00) begin
        exp_oh = 2'b01 << exp_g[nr];
        checks++; if (rsp_valid !== exp_oh || rsp_err !== 1'b0 || rsp_rdata !== 32'h11223344) begin
          failures++; $display("FAIL rr_rsp%0d got=%b/%b/%h exp=%b/0/11223344", nr, rsp_valid, rsp_err, rsp_rdata, exp_oh); end
        checks++; if (ng !== nr + 1) begin failures++; $display("FAIL rr_order%0d grants=%0d exp=%0d", nr, ng, nr + 1); end
        nr++;
      end
      if (nr < 4) @(negedge clk);
    end
    req_valid = 2'b00; arready = 1'b0; rvalid = 1'b0;
    checks++; if (nr !== 4) begin failures++; $display("FAIL rr_timeout got=%0d exp=4", nr); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    set_req(0, 1'b1, 2'd2, 12'h040, 32'hCAFEF00D);
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_ready got=%b exp=01", req_ready); end
    @(negedge clk); req_valid = 2'b00; wready = 1'b1; awready = 1'b0; #1;
    checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || wstrb !== 4'hF || wdata !== 32'hCAFEF00D) begin
      failures++; $display("FAIL bp_c1 got=%b%b/%h/%h exp=11/f/cafef00d", awvalid, wvalid, wstrb, wdata); end
    @(negedge clk); wready = 1'b0; #1;
    checks++; if (wvalid !== 1'b0 || awvalid !== 1'b1 || awaddr !== 12'h040) begin
      failures++; $display("FAIL bp_c2 got=%b%b/%h exp=01/040", wvalid, awvalid, awaddr); end
    @(negedge clk); #1;
    checks++; if (awvalid !== 1'b1 || awaddr !== 12'h040 || bready !== 1'b0) begin
      failures++; $display("FAIL bp_c3 got=%b/%h/%b exp=1/040/0", awvalid, awaddr, bready); end
    @(negedge clk); awready = 1'b1; #1;
    checks++; if (awvalid !== 1'b1 || awaddr !== 12'h040) begin
      failures++; $display("FAIL bp_c4 got=%b/%h exp=1/040", awvalid, awaddr); end
    @(negedge clk); awready = 1'b0; #1;
    checks++; if (awvalid !== 1'b0 || bready !== 1'b1 || rsp_valid !== 2'b00) begin
      failures++; $display("FAIL bp_c5 got=%b%b/%b exp=01/00", awvalid, bready, rsp_valid); end
    @(negedge clk); bvalid = 1'b1; bid = 8'd0; bresp = 1'b0; #1;
    checks++; if (bready !== 1'b1 || rsp_valid !== 2'b00) begin
      failures++; $display("FAIL bp_c6 got=%b/%b exp=1/00", bready, rsp_valid); end
    @(negedge clk); bvalid = 1'b0; #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || bready !== 1'b0) begin
      failures++; $display("FAIL bp_rsp got=%b/%b/%b exp=01/0/0", rsp_valid, rsp_err, bready); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL bp_single got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_errors;
    // misaligned half read from requester 1
    set_req(1, 1'b0, 2'd1, 12'h011, 32'h0);
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL err_mis_ready got=%b exp=10", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    checks++; if (arvalid !== 1'b0 || awvalid !== 1'b0 || rsp_valid !== 2'b00) begin
      failures++; $display("FAIL err_mis_c1 got=%b%b/%b exp=00/00", arvalid, awvalid, rsp_valid); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || arvalid !== 1'b0) begin
      failures++; $display("FAIL err_mis_rsp got=%b/%b/%b exp=10/1/0", rsp_valid, rsp_err, arvalid); end
    @(negedge clk);
    // slave error on an upper-half read from requester 0
    set_req(0, 1'b0, 2'd1, 12'h012, 32'h0);
    req_valid = 2'b01;
    @(negedge clk); req_valid = 2'b00; arready = 1'b1;
    @(negedge clk); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hABCD1234; rid = 8'd0; rlast = 1'b1; rresp = 1'b1;
    @(negedge clk); rvalid = 1'b0; rresp = 1'b0; #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0000ABCD) begin
      failures++; $display("FAIL err_rresp got=%b/%b/%h exp=01/1/0000abcd", rsp_valid, rsp_err, rsp_rdata); end
    @(negedge clk);
    // wrong RID on a byte read from requester 0
    set_req(0, 1'b0, 2'd0, 12'h005, 32'h0);
    req_valid = 2'b01;
    @(negedge clk); req_valid = 2'b00; arready = 1'b1;
    @(negedge clk); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h00007700; rid = 8'd3; rlast = 1'b1;
    @(negedge clk); rvalid = 1'b0; rid = 8'd0; #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h00000077) begin
      failures++; $display("FAIL err_rid got=%b/%b/%h exp=01/1/00000077", rsp_valid, rsp_err, rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    set_req(1, 1'b0, 2'd2, 12'h030, 32'h0);
    req_valid = 2'b10;
    @(negedge clk); req_valid = 2'b00; arready = 1'b1;
    @(negedge clk); arready = 1'b0; #1;
    checks++; if (rready !== 1'b1) begin failures++; $display("FAIL rst_mid_inr got=%b exp=1", rready); end
    #2; rst_n = 1'b0; req_valid = 2'b11; #1;
    checks++; if ({rready, arvalid, awvalid, wvalid, bready, rsp_valid, rsp_err, req_ready} !== 10'd0) begin
      failures++; $display("FAIL rst_mid_ctl got=%b exp=0", {rready, arvalid, awvalid, wvalid, bready, rsp_valid, rsp_err, req_ready}); end
    checks++; if ({araddr, arid, rsp_rdata} !== 52'd0) begin
      failures++; $display("FAIL rst_mid_data got=%h exp=0", {araddr, arid, rsp_rdata}); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rst_mid_norsp got=%b exp=00", rsp_valid); end
    set_req(0, 1'b0, 2'd2, 12'h050, 32'h0);
    rst_n = 1'b1; #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_mid_first got=%b exp=01", req_ready); end
    @(negedge clk); req_valid = 2'b00; arready = 1'b1; #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 12'h050 || arid !== 8'd0) begin
      failures++; $display("FAIL rst_mid_ar got=%b/%h/%h exp=1/050/00", arvalid, araddr, arid); end
    @(negedge clk); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h0BADF00D; rid = 8'd0; rlast = 1'b1; rresp = 1'b0;
    @(negedge clk); rvalid = 1'b0; #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BADF00D) begin
      failures++; $display("FAIL rst_mid_rsp got=%b/%b/%h exp=01/0/0badf00d", rsp_valid, rsp_err, rsp_rdata); end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_round_robin();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpunc_axi_arbiter.md
Name: cpunc_axi_arbiter

Overview:
- Shares the single CPUNC AXI master port among NUM_REQ requesters, such as an ISS bridge, a debug loader and a DMA stub.
- Each requester uses a simple valid/ready request with a one-cycle response pulse.
- A round-robin arbiter grants one requester at a time. An FSM then sequences a single-beat AXI read or write and returns the data and status.
- Exactly one transaction is outstanding at a time, and there are no bursts.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- AXI_ADDR_WIDTH, 12: address width.
- AXI_DATA_WIDTH, 32: data width; fixed at 32 (AXSIZE is hardwired to 2'b10).
- AXI_MASK_WIDTH, AXI_DATA_WIDTH/8: strobe width.

Ports:
- CPUNC_ACLK  in  1  clock
- CPUNC_ARESETn  in  1  asynchronous active-low reset
- REQ_VALID  in  NUM_REQ  request valid, per requester
- REQ_READY  out  NUM_REQ  request accepted, one-hot, per requester
- REQ_WE  in  NUM_REQ  1=write, 0=read
- REQ_SIZE  in  2*NUM_REQ  0=byte, 1=half, 2=word, 3=illegal
- REQ_ADDR  in  AXI_ADDR_WIDTH*NUM_REQ  byte address
- REQ_WDATA  in  32*NUM_REQ  write data, right-justified
- RSP_VALID  out  NUM_REQ  one-cycle completion pulse to the owner
- RSP_RDATA  out  32  read data, right-justified, zero-extended
- RSP_ERR  out  1  error status, qualified by RSP_VALID
- CPUNC_AWADDR/AWVALID  out  AW/1  write address channel; CPUNC_AWREADY in 1
- CPUNC_WDATA/WSTRB/WLAST/WVALID  out  32/4/1/1  write data channel; CPUNC_WREADY in 1
- CPUNC_BID/BRESP/BVALID  in  8/1/1; CPUNC_BREADY out 1
- CPUNC_ARADDR/ARVALID  out  AW/1  read address channel; CPUNC_ARREADY in 1
- CPUNC_RID/RDATA/RRESP/RLAST/RVALID  in  8/32/1/1/1; CPUNC_RREADY out 1
- CPUNC_AWID/ARID, CPUNC_WID  out  8  index of the granted requester (registered)
- CPUNC_AxLN=0, AxSIZE=2'b10, AxBURST=0, AxLOCK=0, AxCACHE=0, AxPROT=0, AxQOS=0  out  constant

Behaviour:
- Reset (asynchronous on CPUNC_ARESETn low):
  - All VALID/READY outputs, REQ_READY, RSP_VALID and RSP_ERR go to 0.
  - All address, data and ID outputs go to 0.
  - The round-robin pointer goes to NUM_REQ-1, so requester 0 wins first.
  - The FSM goes to IDLE. Any in-flight transaction is abandoned with no response, and requesters must re-issue.
- FSM states: IDLE, AR, R, AWW, B, ERR, RSP.
- IDLE:
  - Combinational round-robin among the set REQ_VALID bits, searching from pointer+1.
  - REQ_READY[g] is asserted combinationally in IDLE only.
  - On acceptance: latch we, size, addr, wdata and index g; set the pointer to g.
  - Illegal size, or a misaligned half/word access, goes to ERR. Otherwise a read goes to AR and a write goes to AWW.
- AR:
  - ARVALID=1 with ARADDR=addr, held until ARREADY is sampled high, then go to R.
- R:
  - RREADY=1 until RVALID is sampled; then capture RDATA and go to RSP.
  - err = RRESP | (RID != g) | !RLAST.
- AWW:
  - AWVALID and WVALID are asserted in the same cycle. Each drops independently on its own handshake.
  - Leave for B once both handshakes are complete; same-cycle completion of both is allowed.
  - WLAST=1.
  - WSTRB = base << addr[1:0], where base is 0001, 0011 or 1111 by size.
  - WDATA = wdata << 8*addr[1:0].
- B:
  - BREADY=1 until BVALID is sampled; err = BRESP | (BID != g). Go to RSP.
- ERR:
  - One cycle, no AXI activity; err=1. Go to RSP.
- RSP:
  - RSP_VALID[g]=1 for exactly one cycle, with RSP_ERR=err.
  - RSP_RDATA = (rdata >> 8*addr[1:0]) masked to the access size; 0 for writes.
  - Return to IDLE. No grant is issued in RSP.
- Latency:
  - Zero-wait read: accept at edge 0; ARVALID in cycle 1; RREADY in cycle 2; RSP_VALID in cycle 3.
  - Zero-wait write: also 3 cycles.
  - Minimum spacing between acceptances is 4 cycles.
- VALID stability: AXI VALID and payload outputs are registered and never change while VALID=1 and READY=0.
- Requester responsibility: REQ_VALID may drop without acceptance. A requester must hold its payload stable while its REQ_VALID is high.

Decomposition:
- Package cpunc_axi_pkg contains:
  - size_e (BYTE/HALF/WORD/ILL);
  - state_e;
  - constants AXSIZE_WORD=2'b10 and RESP_OKAY=1'b0;
  - function size_to_strb(size, addr_lo).
- Sub-module cpunc_rr_arbiter, parameterized by NUM_REQ:
  - inputs: req vector, pointer, enable;
  - outputs: one-hot grant and its encoded index.

Test Plan:
1. Single read: req0 reads word at 0x010, slave returns RDATA=0xDEADBEEF with zero wait. ARADDR=0x010, ARID=0; RSP_VALID[0] in cycle 3; RSP_RDATA=0xDEADBEEF, RSP_ERR=0.
2. Byte write: req1 writes size=byte, addr=0x013, wdata=0x5A. AWADDR=0x013, WSTRB=4'b1000, WDATA[31:24]=0x5A, WID=1; then BREADY; RSP_VALID[1] with ERR=0.
3. Round robin: both requesters hold REQ_VALID continuously for 4 transactions. Grant order is 0,1,0,1, and each grant follows the previous RSP.
4. Backpressure: AWREADY delayed 3 cycles, WREADY immediate, BVALID delayed 2 cycles. WVALID drops after 1 cycle; AWVALID/AWADDR stay stable until the handshake; a single RSP pulse is issued.
5. Errors:
   - Half read at 0x011: no ARVALID, RSP_ERR=1 two cycles after acceptance.
   - Read with RRESP=1: RSP_ERR=1, data returned.
   - RID=3 for grant 0: RSP_ERR=1.
6. Reset mid-operation: assert CPUNC_ARESETn low while in the R state. All outputs go to 0 immediately, with no RSP_VALID. After release, requester 0 is granted first.
